// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the control sequencer: opcode constants,
// FSM state and op-class enums, and the PC / writeback select encodings.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_ALU,
        OP_ALUI,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_FENCE,
        OP_ILLEGAL
    } op_class_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_TARGET = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

endpackage

// File: rtl/rv32i_op_class.sv
// Combinational opcode/funct3 classifier. Anything not explicitly legal,
// including SYSTEM and reserved funct3 encodings, is reported as OP_ILLEGAL.
module rv32i_op_class
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output op_class_t  opClass_o
);

    // Map the opcode to a class, then knock out reserved funct3 encodings.
    always_comb begin
        opClass_o = OP_ILLEGAL;
        case (opcode_i)
            OPC_OP:      opClass_o = OP_ALU;
            OPC_OPIMM:   opClass_o = OP_ALUI;
            OPC_LUI:     opClass_o = OP_LUI;
            OPC_AUIPC:   opClass_o = OP_AUIPC;
            OPC_JAL:     opClass_o = OP_JAL;
            OPC_JALR:    if (funct3_i == 3'b000) opClass_o = OP_JALR;
            OPC_BRANCH:  if (funct3_i != 3'b010 && funct3_i != 3'b011) opClass_o = OP_BRANCH;
            OPC_LOAD:    if (!(funct3_i inside {3'b011, 3'b110, 3'b111})) opClass_o = OP_LOAD;
            OPC_STORE:   if (funct3_i < 3'b011) opClass_o = OP_STORE;
            OPC_MISCMEM: opClass_o = OP_FENCE;
            default:     opClass_o = OP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB[/TRAP]).
// Optional feature macro: CTRL_TRAP_EN -- when defined, illegal instructions
// park in TRAP until acknowledged; otherwise they retire as NOPs in DECODE.
module rv32i_ctrl_fsm
    import rv32i_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_branch_taken,
    output logic        o_imem_req,
    input  logic        i_imem_valid,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ready,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic        o_alu_src_imm,
    output logic        o_rf_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_trap,
    input  logic        i_trap_ack,
    output logic [31:0] o_instret
);

    ctrl_state_t state_q;
    op_class_t   opClass_q;
    op_class_t   decodedClass;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        retire;
    logic        isJump;

`ifndef CTRL_TRAP_EN
    logic unusedTrapAck;
    assign unusedTrapAck = i_trap_ack;
`endif

    rv32i_op_class u_opClass (
        .opcode_i  (i_opcode),
        .funct3_i  (i_funct3),
        .opClass_o (decodedClass)
    );

    assign isJump    = (opClass_q == OP_JAL) || (opClass_q == OP_JALR);
    assign o_instret = instret_q;

    // An instruction retires in the one cycle its final PC update is issued.
    always_comb begin
        retire = 1'b0;
        case (state_q)
`ifndef CTRL_TRAP_EN
            ST_DECODE: retire = (decodedClass == OP_ILLEGAL);
`endif
            ST_EXEC:   retire = (opClass_q == OP_BRANCH) || (opClass_q == OP_FENCE);
            ST_MEM:    retire = i_dmem_ready && (opClass_q == OP_STORE);
            ST_WB:     retire = 1'b1;
            default:   retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    // Sequencer state, latched op class and the retired-instruction counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_FETCH;
            opClass_q <= OP_ILLEGAL;
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
            case (state_q)
                ST_FETCH: if (i_imem_valid) state_q <= ST_DECODE;
                ST_DECODE: begin
                    opClass_q <= decodedClass;
                    if (decodedClass != OP_ILLEGAL) state_q <= ST_EXEC;
`ifdef CTRL_TRAP_EN
                    else state_q <= ST_TRAP;
`else
                    else state_q <= ST_FETCH;
`endif
                end
                ST_EXEC: begin
                    case (opClass_q)
                        OP_LOAD, OP_STORE:   state_q <= ST_MEM;
                        OP_BRANCH, OP_FENCE: state_q <= ST_FETCH;
                        default:             state_q <= ST_WB;
                    endcase
                end
                ST_MEM: if (i_dmem_ready) state_q <= (opClass_q == OP_STORE) ? ST_FETCH : ST_WB;
                ST_WB: state_q <= ST_FETCH;
`ifdef CTRL_TRAP_EN
                ST_TRAP: if (i_trap_ack) state_q <= ST_FETCH;
`endif
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Control outputs decoded from state and op class; everything is held low during reset.
    always_comb begin
        o_imem_req    = 1'b0;
        o_ir_we       = 1'b0;
        o_dmem_req    = 1'b0;
        o_dmem_we     = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_sel      = PC_SEL_PLUS4;
        o_alu_src_imm = 1'b0;
        o_rf_we       = 1'b0;
        o_wb_sel      = WB_SEL_ALU;
        o_trap        = 1'b0;
        if (i_rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_we    = i_imem_valid;
                end
                ST_DECODE: begin
`ifndef CTRL_TRAP_EN
                    o_pc_we = (decodedClass == OP_ILLEGAL);
`endif
                end
                ST_EXEC: begin
                    o_alu_src_imm = !((opClass_q == OP_ALU) || (opClass_q == OP_BRANCH));
                    if (opClass_q == OP_BRANCH) begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = {1'b0, i_branch_taken};
                    end else if (opClass_q == OP_FENCE) begin
                        o_pc_we = 1'b1;
                    end
                end
                ST_MEM: begin
                    o_dmem_req = 1'b1;
                    o_dmem_we  = (opClass_q == OP_STORE);
                    o_pc_we    = i_dmem_ready && (opClass_q == OP_STORE);
                end
                ST_WB: begin
                    o_rf_we  = 1'b1;
                    o_pc_we  = 1'b1;
                    o_pc_sel = isJump ? PC_SEL_TARGET : PC_SEL_PLUS4;
                    if (opClass_q == OP_LOAD) o_wb_sel = WB_SEL_MEM;
                    else if (isJump)          o_wb_sel = WB_SEL_PC4;
                end
`ifdef CTRL_TRAP_EN
                ST_TRAP: begin
                    o_trap = 1'b1;
                    if (i_trap_ack) begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = PC_SEL_TRAP;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Self-checking bench for rv32i_ctrl_fsm. A per-instruction timeline model
// builds the expected output vector for every cycle; one compare process
// checks the DUT against it. Honours CTRL_TRAP_EN the same way as the RTL.
module tb_rv32i_ctrl_fsm;
    import rv32i_pkg::*;

    typedef struct packed {
        logic        imemReq;
        logic        irWe;
        logic        dmemReq;
        logic        dmemWe;
        logic        pcWe;
        logic [1:0]  pcSel;
        logic        aluSrcImm;
        logic        rfWe;
        logic [1:0]  wbSel;
        logic        trap;
        logic [31:0] instret;
    } outVec_t;

    typedef struct {
        string       name;
        logic [31:0] word;
        op_class_t   cls;
        int          imemWait;
        int          dmemWait;
        int          ackWait;
        logic        taken;
        logic        noise;
        int          cycNoTrap;
        int          cycTrap;
    } vec_t;

`ifdef CTRL_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        branchTaken = 1'b0;
    logic        imemValid = 1'b0;
    logic        dmemReady = 1'b0;
    logic        trapAck = 1'b0;
    logic        imemReq, dmemReq, dmemWe, irWe, pcWe, aluSrcImm, rfWe, trap;
    logic [1:0]  pcSel, wbSel;
    logic [31:0] instret;
    op_class_t   benchClass;

    outVec_t     expQ[$];
    string       tagQ[$];
    vec_t        tbl[$];
    int          nVectors = 0;
    int          nMiscompares = 0;
    int          cycCount;
    logic [31:0] modelInstret;

    rv32i_ctrl_fsm dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_opcode       (opcode),
        .i_funct3       (funct3),
        .i_branch_taken (branchTaken),
        .o_imem_req     (imemReq),
        .i_imem_valid   (imemValid),
        .o_dmem_req     (dmemReq),
        .o_dmem_we      (dmemWe),
        .i_dmem_ready   (dmemReady),
        .o_ir_we        (irWe),
        .o_pc_we        (pcWe),
        .o_pc_sel       (pcSel),
        .o_alu_src_imm  (aluSrcImm),
        .o_rf_we        (rfWe),
        .o_wb_sel       (wbSel),
        .o_trap         (trap),
        .i_trap_ack     (trapAck),
        .o_instret      (instret)
    );

    rv32i_op_class refClass (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .opClass_o (benchClass)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic outVec_t dutVec();
        outVec_t v;
        v = '{imemReq, irWe, dmemReq, dmemWe, pcWe, pcSel, aluSrcImm, rfWe, wbSel, trap, instret};
        return v;
    endfunction

    function automatic void addVec(string nm, logic [31:0] w, op_class_t c, int iw, int dw, int aw,
                                   logic tk, logic nz, int cNt, int cT);
        vec_t t;
        t = '{nm, w, c, iw, dw, aw, tk, nz, cNt, cT};
        tbl.push_back(t);
    endfunction

    task automatic checkVec(string what, outVec_t act, outVec_t exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, want %h", what, act, exp);
        end
    endtask

    task automatic checkWord(string what, logic [31:0] act, logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, want %h", what, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected outputs.
    task automatic applyStimulus(input outVec_t e, input logic v, input logic r, input logic a,
                                 input logic ret, input string nm);
        imemValid = v;
        dmemReady = r;
        trapAck   = a;
        e.instret = modelInstret;
        expQ.push_back(e);
        tagQ.push_back($sformatf("%s c%0d", nm, cycCount));
        if (ret) modelInstret = modelInstret + 32'd1;
        cycCount++;
        @(negedge clk);
    endtask

    // The final WB cycle of the wrap test: preload the counter and check the adder wraps.
    task automatic wrapCycle();
        imemValid = 1'b0;
        dmemReady = 1'b0;
        trapAck   = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        checkWord("instret_wrap", dut.instret_d, 32'h0000_0000);
        release dut.instret_q;
        cycCount++;
        @(negedge clk);
    endtask

    // Expand one instruction into its per-cycle expected outputs.
    task automatic runInstr(input vec_t t, input bit wrap);
        outVec_t e;
        logic    nz, isLoad, isStore, isJump, isShort;
        nz      = t.noise;
        isLoad  = (t.cls == OP_LOAD);
        isStore = (t.cls == OP_STORE);
        isJump  = (t.cls == OP_JAL) || (t.cls == OP_JALR);
        isShort = (t.cls == OP_BRANCH) || (t.cls == OP_FENCE);
        opcode      = t.word[6:0];
        funct3      = t.word[14:12];
        branchTaken = t.taken;
        cycCount    = 0;
        for (int w = 0; w <= t.imemWait; w++) begin
            e = '0;
            e.imemReq = 1'b1;
            e.irWe    = (w == t.imemWait);
            applyStimulus(e, w == t.imemWait, nz, nz, 1'b0, t.name);
        end
        nVectors++;
        if (benchClass !== t.cls) begin
            nMiscompares++;
            $display("[TB] FAIL class_%s: got %s, want %s", t.name, benchClass.name(), t.cls.name());
        end
        e = '0;
        if (t.cls == OP_ILLEGAL) begin
            if (!TrapEn) begin
                e.pcWe = 1'b1;
                applyStimulus(e, nz, nz, nz, 1'b1, t.name);
            end else begin
                applyStimulus(e, nz, nz, nz, 1'b0, t.name);
                for (int w = 0; w <= t.ackWait; w++) begin
                    e = '0;
                    e.trap = 1'b1;
                    if (w == t.ackWait) begin
                        e.pcWe  = 1'b1;
                        e.pcSel = 2'b10;
                    end
                    applyStimulus(e, nz, nz, w == t.ackWait, 1'b0, t.name);
                end
            end
        end else begin
            applyStimulus(e, nz, nz, nz, 1'b0, t.name);
            e = '0;
            e.aluSrcImm = !((t.cls == OP_ALU) || (t.cls == OP_BRANCH));
            if (t.cls == OP_BRANCH) begin
                e.pcWe  = 1'b1;
                e.pcSel = {1'b0, t.taken};
            end
            if (t.cls == OP_FENCE) e.pcWe = 1'b1;
            applyStimulus(e, nz, nz, nz, isShort, t.name);
            if (isLoad || isStore) begin
                for (int w = 0; w <= t.dmemWait; w++) begin
                    e = '0;
                    e.dmemReq = 1'b1;
                    e.dmemWe  = isStore;
                    e.pcWe    = isStore && (w == t.dmemWait);
                    applyStimulus(e, nz, w == t.dmemWait, nz, isStore && (w == t.dmemWait), t.name);
                end
            end
            if (!isShort && !isStore) begin
                if (wrap) begin
                    wrapCycle();
                end else begin
                    e = '0;
                    e.rfWe  = 1'b1;
                    e.pcWe  = 1'b1;
                    e.wbSel = isLoad ? 2'b01 : (isJump ? 2'b10 : 2'b00);
                    e.pcSel = isJump ? 2'b01 : 2'b00;
                    applyStimulus(e, nz, nz, nz, 1'b1, t.name);
                end
            end
        end
        checkWord({"cycles_", t.name}, cycCount, TrapEn ? t.cycTrap : t.cycNoTrap);
    endtask

    // Abort a load in MEM with reset and confirm everything drops immediately.
    task automatic resetMidMem();
        outVec_t e;
        opcode   = 7'b0000011;
        funct3   = 3'b010;
        cycCount = 0;
        e = '0; e.imemReq = 1'b1; e.irWe = 1'b1;
        applyStimulus(e, 1'b1, 1'b0, 1'b0, 1'b0, "lw_reset");
        e = '0;
        applyStimulus(e, 1'b0, 1'b0, 1'b0, 1'b0, "lw_reset");
        e = '0; e.aluSrcImm = 1'b1;
        applyStimulus(e, 1'b0, 1'b0, 1'b0, 1'b0, "lw_reset");
        e = '0; e.dmemReq = 1'b1;
        applyStimulus(e, 1'b0, 1'b0, 1'b0, 1'b0, "lw_reset");
        applyStimulus(e, 1'b0, 1'b0, 1'b0, 1'b0, "lw_reset");
        rstN = 1'b0;
        #1;
        checkVec("reset_mid_mem", dutVec(), '0);
        @(negedge clk);
        rstN = 1'b1;
        modelInstret = '0;
    endtask

    // Compare the DUT against the queued expectation shortly after each falling edge.
    initial begin
        outVec_t e;
        string   tag;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() != 0) begin
                e   = expQ.pop_front();
                tag = tagQ.pop_front();
                checkVec(tag, dutVec(), e);
            end
        end
    end

    // Bound the run in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed instruction sequence.
    initial begin
        addVec("addi",     32'h00F00513, OP_ALUI,    0, 0, 0, 1'b0, 1'b0, 4, 4);
        addVec("lw_wait",  32'h00052503, OP_LOAD,    0, 3, 0, 1'b0, 1'b0, 8, 8);
        addVec("beq_t",    32'h00000463, OP_BRANCH,  0, 0, 0, 1'b1, 1'b0, 3, 3);
        addVec("beq_nt",   32'h00000463, OP_BRANCH,  0, 0, 0, 1'b0, 1'b0, 3, 3);
        addVec("jal",      32'h008000EF, OP_JAL,     0, 0, 0, 1'b0, 1'b0, 4, 4);
        addVec("illegal",  32'h0000007F, OP_ILLEGAL, 0, 0, 2, 1'b0, 1'b0, 2, 5);
        addVec("sw_wait",  32'h00A5A023, OP_STORE,   2, 1, 0, 1'b0, 1'b1, 7, 7);
        addVec("add",      32'h00B50533, OP_ALU,     0, 0, 0, 1'b1, 1'b0, 4, 4);
        addVec("lui",      32'h123452B7, OP_LUI,     0, 0, 0, 1'b0, 1'b0, 4, 4);
        addVec("auipc",    32'h00000517, OP_AUIPC,   0, 0, 0, 1'b0, 1'b0, 4, 4);
        addVec("jalr",     32'h000080E7, OP_JALR,    0, 0, 0, 1'b0, 1'b1, 4, 4);
        addVec("jalr_f3",  32'h000090E7, OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 2, 3);
        addVec("fence",    32'h0FF0000F, OP_FENCE,   0, 0, 0, 1'b0, 1'b1, 3, 3);
        addVec("ecall",    32'h00000073, OP_ILLEGAL, 0, 0, 1, 1'b0, 1'b1, 2, 4);
        addVec("br_f3_2",  32'h00002063, OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 2, 3);
        addVec("ld_f3_3",  32'h00003003, OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 2, 3);
        addVec("lbu",      32'h00004003, OP_LOAD,    0, 0, 0, 1'b0, 1'b0, 5, 5);
        addVec("st_f3_3",  32'h00003023, OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 2, 3);
        addVec("bne_t_nz", 32'h00001063, OP_BRANCH,  1, 0, 0, 1'b1, 1'b1, 4, 4);

        modelInstret = '0;
        #1 rstN = 1'b0;
        @(negedge clk);
        #1;
        checkVec("reset_state", dutVec(), '0);
        @(negedge clk);
        rstN = 1'b1;

        foreach (tbl[i]) runInstr(tbl[i], 1'b0);
        checkWord("instret_total", modelInstret, TrapEn ? 32'd13 : 32'd19);

        resetMidMem();
        runInstr(tbl[0], 1'b0);
        checkWord("instret_after_abort", modelInstret, 32'd1);

        runInstr(tbl[0], 1'b1);
        rstN = 1'b0;
        #1;
        checkWord("instret_reset", instret, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/rv32i_ctrl_fsm.md
# rv32i_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the instruction-register, PC, register-file and data-memory enables from the opcode/funct3 fields produced by `decoder`. Holds the instruction- and data-memory request/ready handshakes and counts retired instructions.

## Interface
- No parameters; XLEN fixed at 32.
- `i_clk  in  1`  core clock, rising edge.
- `i_rst_n  in  1`  asynchronous, active-low reset.
- `i_opcode  in  7`  from `decoder`, valid while the IR holds the current instruction.
- `i_funct3  in  3`  from `decoder`.
- `i_branch_taken  in  1`  ALU compare result; sampled in EXEC for branches.
- `o_imem_req  out  1`  instruction fetch request.
- `i_imem_valid  in  1`  fetch data valid.
- `o_dmem_req  out  1`  data access request.
- `o_dmem_we  out  1`  1 = store.
- `i_dmem_ready  in  1`  data access complete.
- `o_ir_we  out  1`  load the IR.
- `o_pc_we  out  1`  update the PC.
- `o_pc_sel  out  2`  PC source: 00 = pc+4, 01 = branch/jump target, 10 = trap vector.
- `o_alu_src_imm  out  1`  ALU operand B: 1 = immediate, 0 = rs2.
- `o_rf_we  out  1`  register-file write.
- `o_wb_sel  out  2`  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
- `o_trap  out  1`  illegal instruction pending (`CTRL_TRAP_EN` only; otherwise tied 0).
- `i_trap_ack  in  1`  trap acknowledged.
- `o_instret  out  32`  retired-instruction counter.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - `o_imem_req` = 1.
  - When `i_imem_valid` = 1: `o_ir_we` = 1 in the same cycle, then go to DECODE.
  - Otherwise hold.
- **DECODE**
  - Classify `i_opcode`/`i_funct3` into a registered op class: ALU, ALUI, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, FENCE, ILLEGAL.
  - ILLEGAL cases:
    - any unlisted opcode, including SYSTEM;
    - JALR with funct3 ≠ 000;
    - BRANCH with funct3 010 or 011;
    - LOAD with funct3 011, 110 or 111;
    - STORE with funct3 ≥ 011.
  - Legal classes go to EXEC. ILLEGAL is handled per Configuration.
- **EXEC**
  - `o_alu_src_imm` = 1 for every class except ALU and BRANCH.
  - ALU, ALUI, LUI, AUIPC, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `o_pc_we` = 1, `o_pc_sel` = {0, `i_branch_taken`}, retire, go to FETCH.
  - FENCE: `o_pc_we` = 1, `o_pc_sel` = 00, retire, go to FETCH.
- **MEM**
  - `o_dmem_req` = 1 and `o_dmem_we` = (class == STORE), both held until `i_dmem_ready`.
  - On ready: STORE sets `o_pc_we` = 1, `o_pc_sel` = 00, retires and goes to FETCH; LOAD goes to WB.
- **WB**
  - `o_rf_we` = 1. x0 writes are suppressed by the register file, not here.
  - `o_wb_sel`: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - `o_pc_we` = 1. `o_pc_sel` = 01 for JAL/JALR, 00 otherwise.
  - Retire, go to FETCH.
- **Retire**: `o_instret` increments by 1 in the cycle that `o_pc_we` is asserted by a retiring instruction. Wraps from FFFF_FFFF to 0.

## Timing
- Reset (asynchronous, `i_rst_n` low): state = FETCH, op class = ILLEGAL, `o_instret` = 0.
- All outputs are 0 while reset is asserted. `o_imem_req` = 1 in the first cycle after deassertion.
- Reset asserted mid-instruction aborts it immediately: no retire, no PC or register-file write.
- All outputs are decoded from state and the registered op class, with three combinational exceptions:
  - `o_ir_we` follows `i_imem_valid` in FETCH;
  - `o_pc_sel[0]` follows `i_branch_taken` in EXEC;
  - MEM/TRAP exit enables follow `i_dmem_ready` / `i_trap_ack`.
- Zero-wait cycle counts:
  - ALU, ALUI, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, FENCE: 3 cycles.
- Each memory wait cycle adds one cycle.
- `i_imem_valid` outside FETCH and `i_dmem_ready` outside MEM are ignored.
- Request signals are never dropped before their response arrives.
- `o_pc_we` and `o_rf_we` are single-cycle pulses, at most one per instruction.

## Configuration
- Macro: `CTRL_TRAP_EN`.
- Defined:
  - ILLEGAL goes DECODE → TRAP.
  - TRAP holds `o_trap` = 1 until `i_trap_ack`.
  - On ack: `o_pc_we` = 1, `o_pc_sel` = 10, go to FETCH, no retire.
- Undefined:
  - TRAP state and `i_trap_ack` logic are absent; `o_trap` is tied 0.
  - ILLEGAL is treated as a NOP: in DECODE, `o_pc_we` = 1, `o_pc_sel` = 00, retire, go to FETCH.

## Structure
- Shared package `rv32i_pkg`:
  - RV32I opcode constants (7-bit);
  - `ctrl_state_t` enum;
  - `op_class_t` enum;
  - `pc_sel` and `wb_sel` encodings.
- Sub-module `rv32i_op_class`: purely combinational opcode/funct3 → `op_class_t` classifier including the illegal checks. Reused by the bench's reference model.

## Test plan
- **ADDI fetch and retire.** Reset released, IR 00F00513 (ADDI x10, x0, 15), `i_imem_valid` on the first FETCH cycle → retires after 4 cycles:
  - `o_rf_we` and `o_pc_we` pulse together in WB;
  - `o_wb_sel` = 00, `o_alu_src_imm` = 1;
  - `o_instret` = 1.
- **LOAD with wait states.** LW 00052503, `i_dmem_ready` delayed 3 cycles → `o_dmem_req` held 4 cycles with `o_dmem_we` = 0, then WB with `o_wb_sel` = 01. Total 8 cycles.
- **BRANCH taken / not taken.** BEQ 00000463 with `i_branch_taken` = 1, then repeat with 0 → each completes in 3 cycles:
  - `o_pc_sel` = 01 when taken, 00 when not;
  - `o_rf_we` never asserted.
- **JAL writeback.** JAL 008000EF → WB with `o_wb_sel` = 10, `o_pc_sel` = 01, `o_rf_we` = 1.
- **Illegal opcode.** Opcode 1111111:
  - with `CTRL_TRAP_EN`: `o_trap` = 1 until `i_trap_ack`, then `o_pc_sel` = 10; `o_instret` unchanged;
  - without: NOP retire; `o_instret` increments.
- **Reset mid-access and counter wrap.** Assert `i_rst_n` low during MEM → all outputs 0 and `o_instret` = 0 immediately; first post-reset cycle has `o_imem_req` = 1. Separately, force `o_instret` = FFFF_FFFF and retire one instruction → `o_instret` = 0.
